// File: rtl/quote_engine.sv
// -----------------------------------------------------------------------------
// quote_engine
//   Market-making quote stage. Takes sigma^2 and mid price per update from the
//   volatility stage, keeps a signed per-stock inventory from fill reports, and
//   emits an inventory-skewed, symmetric bid/ask quote with side enables.
//
// Ports
//   i_clk, i_reset                 rising-edge clock, synchronous active-high reset
//   i_data_valid                   sample strobe (no backpressure)
//   i_volatility, i_curr_price     sigma^2 and mid price for i_stock_id
//   i_stock_id                     stock of the sample
//   i_fill_valid, i_fill_side      fill strobe; side 0 = bid filled (+qty), 1 = ask filled (-qty)
//   i_fill_qty, i_fill_stock       unsigned fill quantity and its stock
//   o_quote_valid                  one-cycle pulse marking a new quote
//   o_stock_id, o_bid_price,
//   o_ask_price, o_bid_en, o_ask_en quote contents; held while o_quote_valid = 0
//
// Handshake: every strobe (i_data_valid, i_fill_valid, o_quote_valid) is a
// valid-only pulse. There is no ready; the producer never stalls and the
// consumer must take o_* in the single cycle o_quote_valid is high.
//
// Pipeline: sample registered into S1 at edge N, S2 at N+1, S3 at N+2, outputs
// at N+3. A fill and a sample on the same stock at the same edge: S1 captures
// the pre-fill inventory, the fill lands at that same edge.
// -----------------------------------------------------------------------------
module quote_engine #(
  parameter int DATA_WIDTH       = 32,
  parameter int INV_WIDTH        = 16,
  parameter int NUM_STOCKS       = 4,
  parameter int GAMMA            = 16,
  parameter int GAMMA_FRAC       = 4,
  parameter int BASE_HALF_SPREAD = 2,
  parameter int MAX_INV          = 100
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_data_valid,
  input  logic [DATA_WIDTH-1:0]         i_volatility,
  input  logic [DATA_WIDTH-1:0]         i_curr_price,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  input  logic                          i_fill_valid,
  input  logic                          i_fill_side,
  input  logic [INV_WIDTH-2:0]          i_fill_qty,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_fill_stock,
  output logic                          o_quote_valid,
  output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
  output logic [DATA_WIDTH-1:0]         o_bid_price,
  output logic [DATA_WIDTH-1:0]         o_ask_price,
  output logic                          o_bid_en,
  output logic                          o_ask_en
);

  localparam int SW  = $clog2(NUM_STOCKS);
  localparam int PW  = DATA_WIDTH + 32;              // vol*GAMMA product width
  localparam int SKW = DATA_WIDTH + INV_WIDTH + 1;   // signed skew width
  localparam int WW  = SKW + 2;                      // price arithmetic width

  localparam logic [DATA_WIDTH-1:0]       DMAX   = '1;
  localparam logic signed [INV_WIDTH:0]   INV_HI = (INV_WIDTH+1)'(MAX_INV);
  localparam logic signed [INV_WIDTH:0]   INV_LO = -INV_HI;
  localparam logic signed [INV_WIDTH-1:0] INV_HI_N = INV_WIDTH'(MAX_INV);
  localparam logic signed [INV_WIDTH-1:0] INV_LO_N = -INV_HI_N;

  // ---------------------------------------------------------------------------
  // Inventory
  // ---------------------------------------------------------------------------
  logic signed [INV_WIDTH-1:0] inv_q [NUM_STOCKS];

  logic                      fill_ok;
  logic signed [INV_WIDTH:0] fill_sum;
  logic signed [INV_WIDTH:0] fill_clamped;

  always_comb begin
    fill_ok      = i_fill_valid && (i_fill_qty != '0) && (32'(i_fill_stock) < NUM_STOCKS);
    fill_sum     = '0;
    fill_clamped = '0;
    if (fill_ok) begin
      // One extra bit so inv +/- qty cannot wrap before the clamp.
      if (i_fill_side)
        fill_sum = (INV_WIDTH+1)'(inv_q[i_fill_stock]) - $signed({2'b00, i_fill_qty});
      else
        fill_sum = (INV_WIDTH+1)'(inv_q[i_fill_stock]) + $signed({2'b00, i_fill_qty});
      if (fill_sum > INV_HI)      fill_clamped = INV_HI;
      else if (fill_sum < INV_LO) fill_clamped = INV_LO;
      else                        fill_clamped = fill_sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STOCKS; i++) inv_q[i] <= '0;
    end else if (fill_ok) begin
      inv_q[i_fill_stock] <= fill_clamped[INV_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S1: capture sample, pre-fill inventory, and saturated risk term
  // ---------------------------------------------------------------------------
  logic                        id_ok;
  logic signed [INV_WIDTH-1:0] inv_sel;
  logic [PW-1:0]               risk_prod;
  logic [PW-1:0]               risk_shift;
  logic [DATA_WIDTH-1:0]       risk_c;

  always_comb begin
    id_ok      = 32'(i_stock_id) < NUM_STOCKS;
    inv_sel    = id_ok ? inv_q[i_stock_id] : '0;
    risk_prod  = PW'(i_volatility) * PW'(GAMMA);
    risk_shift = risk_prod >> GAMMA_FRAC;
    risk_c     = (|risk_shift[PW-1:DATA_WIDTH]) ? DMAX : risk_shift[DATA_WIDTH-1:0];
  end

  logic                        s1_valid;
  logic [SW-1:0]               s1_id;
  logic [DATA_WIDTH-1:0]       s1_price;
  logic signed [INV_WIDTH-1:0] s1_inv;
  logic [DATA_WIDTH-1:0]       s1_risk;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_price <= '0;
      s1_inv   <= '0;
      s1_risk  <= '0;
    end else begin
      s1_valid <= i_data_valid;
      s1_id    <= i_stock_id;
      s1_price <= i_curr_price;
      s1_inv   <= inv_sel;
      s1_risk  <= risk_c;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: skew = inv * risk, half = risk/2 + base (saturated)
  // ---------------------------------------------------------------------------
  logic signed [SKW-1:0]   skew_c;
  logic [DATA_WIDTH:0]     half_sum;
  logic [DATA_WIDTH-1:0]   half_c;

  always_comb begin
    skew_c   = SKW'(s1_inv) * SKW'($signed({1'b0, s1_risk}));
    half_sum = {1'b0, s1_risk >> 1} + (DATA_WIDTH+1)'(BASE_HALF_SPREAD);
    half_c   = half_sum[DATA_WIDTH] ? DMAX : half_sum[DATA_WIDTH-1:0];
  end

  logic                        s2_valid;
  logic [SW-1:0]               s2_id;
  logic [DATA_WIDTH-1:0]       s2_price;
  logic signed [INV_WIDTH-1:0] s2_inv;
  logic signed [SKW-1:0]       s2_skew;
  logic [DATA_WIDTH-1:0]       s2_half;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_price <= '0;
      s2_inv   <= '0;
      s2_skew  <= '0;
      s2_half  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_price <= s1_price;
      s2_inv   <= s1_inv;
      s2_skew  <= skew_c;
      s2_half  <= half_c;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: reservation price and raw (unclamped) bid/ask
  // ---------------------------------------------------------------------------
  logic signed [WW-1:0] r_c;
  logic signed [WW-1:0] half_w;
  logic signed [WW-1:0] bid_w;
  logic signed [WW-1:0] ask_w;

  always_comb begin
    r_c    = WW'($signed({1'b0, s2_price})) - WW'(s2_skew);
    half_w = WW'($signed({1'b0, s2_half}));
    bid_w  = r_c - half_w;
    ask_w  = r_c + half_w;
  end

  logic                 s3_valid;
  logic [SW-1:0]        s3_id;
  logic signed [WW-1:0] s3_bid;
  logic signed [WW-1:0] s3_ask;
  logic                 s3_bid_en;
  logic                 s3_ask_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s3_valid  <= 1'b0;
      s3_id     <= '0;
      s3_bid    <= '0;
      s3_ask    <= '0;
      s3_bid_en <= 1'b0;
      s3_ask_en <= 1'b0;
    end else begin
      s3_valid  <= s2_valid;
      s3_id     <= s2_id;
      s3_bid    <= bid_w;
      s3_ask    <= ask_w;
      s3_bid_en <= s2_inv < INV_HI_N;
      s3_ask_en <= s2_inv > INV_LO_N;
    end
  end

  // ---------------------------------------------------------------------------
  // Output: clamp to [0, 2^DATA_WIDTH-1]; hold between quotes
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] clamp_price(input logic signed [WW-1:0] v);
    if (v[WW-1])                  return '0;
    else if (|v[WW-2:DATA_WIDTH]) return DMAX;
    else                          return v[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_quote_valid <= 1'b0;
      o_stock_id    <= '0;
      o_bid_price   <= '0;
      o_ask_price   <= '0;
      o_bid_en      <= 1'b0;
      o_ask_en      <= 1'b0;
    end else begin
      o_quote_valid <= s3_valid;
      if (s3_valid) begin
        o_stock_id  <= s3_id;
        o_bid_price <= clamp_price(s3_bid);
        o_ask_price <= clamp_price(s3_ask);
        o_bid_en    <= s3_bid_en;
        o_ask_en    <= s3_ask_en;
      end
    end
  end

endmodule

// File: tb/tb_quote_engine.sv
module tb_quote_engine;

  typedef struct packed {
    int          cyc;
    logic        valid;
    logic [1:0]  id;
    logic [31:0] bid;
    logic [31:0] ask;
    logic        bid_en;
    logic        ask_en;
  } quote_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_reset = 1'b1;
  logic        i_data_valid = 1'b0;
  logic [31:0] i_volatility = '0;
  logic [31:0] i_curr_price = '0;
  logic [1:0]  i_stock_id = '0;
  logic        i_fill_valid = 1'b0;
  logic        i_fill_side = 1'b0;
  logic [14:0] i_fill_qty = '0;
  logic [1:0]  i_fill_stock = '0;

  logic        o_quote_valid, o_bid_en, o_ask_en;
  logic [1:0]  o_stock_id;
  logic [31:0] o_bid_price, o_ask_price;

  logic        g_quote_valid, g_bid_en, g_ask_en;
  logic [1:0]  g_stock_id;
  logic [31:0] g_bid_price, g_ask_price;

  quote_engine u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_data_valid(i_data_valid),
    .i_volatility(i_volatility), .i_curr_price(i_curr_price), .i_stock_id(i_stock_id),
    .i_fill_valid(i_fill_valid), .i_fill_side(i_fill_side), .i_fill_qty(i_fill_qty),
    .i_fill_stock(i_fill_stock), .o_quote_valid(o_quote_valid), .o_stock_id(o_stock_id),
    .o_bid_price(o_bid_price), .o_ask_price(o_ask_price), .o_bid_en(o_bid_en),
    .o_ask_en(o_ask_en)
  );

  // Second instance with GAMMA = 2.0 to reach risk saturation.
  quote_engine #(.GAMMA(32)) u_dut_g32 (
    .i_clk(clk), .i_reset(i_reset), .i_data_valid(i_data_valid),
    .i_volatility(i_volatility), .i_curr_price(i_curr_price), .i_stock_id(i_stock_id),
    .i_fill_valid(i_fill_valid), .i_fill_side(i_fill_side), .i_fill_qty(i_fill_qty),
    .i_fill_stock(i_fill_stock), .o_quote_valid(g_quote_valid), .o_stock_id(g_stock_id),
    .o_bid_price(g_bid_price), .o_ask_price(g_ask_price), .o_bid_en(g_bid_en),
    .o_ask_en(g_ask_en)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  quote_t exp_q[$];
  quote_t exp_g_q[$];
  quote_t last_main = '0;
  quote_t last_g = '0;
  int inv_m[4];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic quote_t model(input longint price, input longint vol, input longint inv,
                                   input longint gamma, input logic [1:0] id, input int c);
    quote_t q;
    longint maxv, risk, half, r, b, a;
    maxv = 64'h0000_0000_FFFF_FFFF;
    risk = (vol * gamma) / 16;
    if (risk > maxv) risk = maxv;
    half = risk / 2 + 2;
    if (half > maxv) half = maxv;
    r = price - inv * risk;
    b = r - half;
    a = r + half;
    if (b < 0) b = 0; else if (b > maxv) b = maxv;
    if (a < 0) a = 0; else if (a > maxv) a = maxv;
    q.cyc    = c;
    q.valid  = 1'b1;
    q.id     = id;
    q.bid    = b[31:0];
    q.ask    = a[31:0];
    q.bid_en = inv < 100;
    q.ask_en = inv > -100;
    return q;
  endfunction

  task automatic check_quote(input string tag, input quote_t obs, input bit have,
                             input quote_t e, input quote_t last);
    if (have) begin
      chk({tag, "_valid"},  64'(obs.valid),  64'(1'b1));
      chk({tag, "_id"},     64'(obs.id),     64'(e.id));
      chk({tag, "_bid"},    64'(obs.bid),    64'(e.bid));
      chk({tag, "_ask"},    64'(obs.ask),    64'(e.ask));
      chk({tag, "_bid_en"}, 64'(obs.bid_en), 64'(e.bid_en));
      chk({tag, "_ask_en"}, 64'(obs.ask_en), 64'(e.ask_en));
    end else begin
      chk({tag, "_idle_valid"}, 64'(obs.valid), 64'(1'b0));
      chk({tag, "_hold"}, {obs.bid, obs.ask}, {last.bid, last.ask});
    end
  endtask

  // Monitor samples 1 time unit after each rising edge.
  quote_t mon_obs, mon_e;
  bit     mon_have;
  always @(posedge clk) begin
    #1;
    mon_have = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    mon_e = '0;
    if (mon_have) mon_e = exp_q.pop_front();
    mon_obs = '{cyc, o_quote_valid, o_stock_id, o_bid_price, o_ask_price, o_bid_en, o_ask_en};
    check_quote("main", mon_obs, mon_have, mon_e, last_main);
    if (mon_have) last_main = mon_e;

    mon_have = (exp_g_q.size() > 0) && (exp_g_q[0].cyc == cyc);
    mon_e = '0;
    if (mon_have) mon_e = exp_g_q.pop_front();
    mon_obs = '{cyc, g_quote_valid, g_stock_id, g_bid_price, g_ask_price, g_bid_en, g_ask_en};
    check_quote("g32", mon_obs, mon_have, mon_e, last_g);
    if (mon_have) last_g = mon_e;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit dv, input logic [31:0] price, input logic [31:0] vol,
                       input logic [1:0] id, input bit fv, input bit side,
                       input logic [14:0] qty, input logic [1:0] fst);
    int v;
    @(negedge clk);
    i_data_valid = dv;  i_curr_price = price; i_volatility = vol; i_stock_id = id;
    i_fill_valid = fv;  i_fill_side = side;   i_fill_qty = qty;   i_fill_stock = fst;
    // Sample sees the pre-fill inventory; output appears after edge N+3.
    if (dv) begin
      exp_q.push_back(model(price, vol, inv_m[id], 16, id, cyc + 4));
      exp_g_q.push_back(model(price, vol, inv_m[id], 32, id, cyc + 4));
    end
    if (fv && qty != 0) begin
      v = side ? inv_m[fst] - int'(qty) : inv_m[fst] + int'(qty);
      if (v > 100) v = 100;
      if (v < -100) v = -100;
      inv_m[fst] = v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic sample(input logic [31:0] price, input logic [31:0] vol, input logic [1:0] id);
    drive(1'b1, price, vol, id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic fill(input bit side, input logic [14:0] qty, input logic [1:0] fst);
    drive(1'b0, '0, '0, '0, 1'b1, side, qty, fst);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    i_reset = 1'b1;
    i_data_valid = 1'b0;
    i_fill_valid = 1'b0;
    exp_q.delete();
    exp_g_q.delete();
    last_main = '0;
    last_g = '0;
    for (int i = 0; i < 4; i++) inv_m[i] = 0;
    repeat (n) @(negedge clk);
    i_reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 4; i++) inv_m[i] = 0;
    do_reset(3);
    @(posedge clk); #2;
    chk("reset_valid", 64'(o_quote_valid), 64'(0));
    chk("reset_bid",   64'(o_bid_price),   64'(0));
    chk("reset_ask",   64'(o_ask_price),   64'(0));
    chk("reset_en",    64'({o_bid_en, o_ask_en}), 64'(0));

    // Basic quote, inv 0: bid 978 / ask 1022.
    sample(1000, 40, 0);
    idle(5);

    // Buy 2 on stock 0 then re-sample: bid 898 / ask 942.
    fill(1'b0, 2, 0);
    sample(1000, 40, 0);
    idle(5);

    // Fill and sample same edge on stock 1, then back-to-back sample sees inv 3.
    drive(1'b1, 1000, 40, 1, 1'b1, 1'b0, 3, 1);
    sample(1000, 40, 1);
    idle(5);

    // Stock 2: buys 50 + 55 saturate at +100, then sell 250 -> -100.
    fill(1'b0, 50, 2);
    fill(1'b0, 55, 2);
    sample(5000, 4, 2);
    fill(1'b1, 250, 2);
    sample(5000, 4, 2);
    // Zero-qty fill must not disturb stock 2.
    fill(1'b0, 0, 2);
    sample(5000, 4, 2);
    idle(5);

    // Low price clamps bid to 0.
    sample(10, 40, 3);
    // Saturating risk on the GAMMA=2.0 instance, large price clamps ask.
    sample(32'h8000_0000, 32'hFFFF_FFFF, 3);
    sample(32'h8000_0000, 32'h9000_0000, 3);
    idle(5);

    // Random back-to-back samples with interleaved fills.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, $urandom_range(200000, 100000), $urandom_range(1000, 0),
            2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            15'($urandom_range(20, 0)), 2'($urandom_range(3, 0)));
    end
    idle(6);

    // Three samples in flight, then a one-cycle reset: no quote may appear.
    fill(1'b1, 7, 2);
    sample(1000, 40, 0);
    sample(1000, 40, 1);
    sample(1000, 40, 2);
    do_reset(1);
    idle(6);
    // Inventories are back to zero: stock 2 quotes as inv 0 with both sides on.
    sample(1000, 40, 2);
    sample(1000, 40, 0);
    idle(6);

    chk("drain_main", 64'(exp_q.size()),   64'(0));
    chk("drain_g32",  64'(exp_g_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
